// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - op encodings and helpers shared by the pipelined shifter
package shifter_pkg;

    localparam logic [2:0] OP_SRL  = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;

    function automatic logic is_left(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/shift_level.sv
// rtl/shift_level.sv - one log level of the barrel shifter, shifting by AMT when enabled
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] shifted
);

    logic [WIDTH-1:0] rol;
    logic [WIDTH-1:0] ror;

    assign rol = {data[WIDTH-AMT-1:0], data[WIDTH-1:WIDTH-AMT]};
    assign ror = {data[AMT-1:0], data[WIDTH-1:AMT]};

    // SRA applied level by level keeps filling from the original sign bit
    always_comb begin
        shifted = data;
        if (enable) begin
            if (is_left(op)) begin
                shifted = (op == OP_ROL) ? rol : (data << AMT);
            end else begin
                case (op)
                    OP_SRL:  shifted = data >> AMT;
                    OP_SRA:  shifted = $signed(data) >>> AMT;
                    OP_ROR:  shifted = ror;
                    default: shifted = data;
                endcase
            end
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - barrel shifter with PIPE register stages and valid/ready flow control
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int PIPE  = 2,
    parameter  int TAG_W = 5,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    logic [WIDTH-1:0] d_q     [PIPE];
    logic [SHW-1:0]   amt_q   [PIPE];
    logic [2:0]       op_q    [PIPE];
    logic [TAG_W-1:0] tag_q   [PIPE];
    logic [PIPE-1:0]  v_q;

    logic [WIDTH-1:0] src_data [PIPE];
    logic [SHW-1:0]   src_amt  [PIPE];
    logic [2:0]       src_op   [PIPE];
    logic [TAG_W-1:0] src_tag  [PIPE];
    logic [PIPE-1:0]  src_v;
    logic [WIDTH-1:0] st_res   [PIPE];

    // ld[i]: stage i may load this cycle; ld[PIPE] stands for the consumer
    logic [PIPE:0]    ld;
    logic [PIPE-1:0]  adv;

    always_comb begin
        adv      = '0;
        ld       = '0;
        ld[PIPE] = out_ready;
        for (int i = PIPE - 1; i >= 0; i--) begin
            adv[i] = v_q[i] & ld[i+1];
            ld[i]  = ~v_q[i] | adv[i];
        end
    end

    assign in_ready = ~flush & ld[0];

    always_comb begin
        src_data[0] = in_data;
        src_amt[0]  = in_shamt;
        src_op[0]   = in_op;
        src_tag[0]  = in_tag;
        src_v[0]    = in_valid & in_ready;
        for (int i = 1; i < PIPE; i++) begin
            src_data[i] = d_q[i-1];
            src_amt[i]  = amt_q[i-1];
            src_op[i]   = op_q[i-1];
            src_tag[i]  = tag_q[i-1];
            src_v[i]    = v_q[i-1];
        end
    end

    for (genvar s = 0; s < PIPE; s++) begin : g_stage
        localparam int LO = s * SHW / PIPE;
        localparam int HI = (s + 1) * SHW / PIPE;

        logic [WIDTH-1:0] chain [HI-LO+1];

        assign chain[0] = src_data[s];

        for (genvar j = 0; j < HI - LO; j++) begin : g_level
            shift_level #(
                .WIDTH (WIDTH),
                .AMT   (1 << (LO + j))
            ) u_level (
                .data    (chain[j]),
                .enable  (src_amt[s][LO+j]),
                .op      (src_op[s]),
                .shifted (chain[j+1])
            );
        end

        assign st_res[s] = chain[HI-LO];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < PIPE; i++) begin
                d_q[i]   <= '0;
                amt_q[i] <= '0;
                op_q[i]  <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PIPE; i++) begin
                if (flush) begin
                    v_q[i] <= 1'b0;
                end else if (ld[i]) begin
                    v_q[i] <= src_v[i];
                end
                if (ld[i] && src_v[i]) begin
                    d_q[i]   <= st_res[i];
                    amt_q[i] <= src_amt[i];
                    op_q[i]  <= src_op[i];
                    tag_q[i] <= src_tag[i];
                end
            end
        end
    end

    assign out_valid = v_q[PIPE-1];
    assign out_data  = d_q[PIPE-1];
    assign out_tag   = tag_q[PIPE-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb/tb_pipelined_shifter.sv - directed self-checking bench for pipelined_shifter at PIPE 2, 1 and 5
module tb_pipelined_shifter;

    localparam int W  = 32;
    localparam int TW = 5;
    localparam int SW = 5;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] d;
        logic [4:0]  sh;
        logic [31:0] e;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic          aux_en = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic [SW-1:0] in_shamt = '0;
    logic [2:0]    in_op = '0;
    logic [TW-1:0] in_tag = '0;
    logic          aux_valid;
    logic          in_ready, rdy1, rdy5;
    logic [2:0]    ov;
    logic [W-1:0]  od [3];
    logic [TW-1:0] ot [3];

    int n_checks = 0;
    int n_fail = 0;
    int pl [3] = '{2, 1, 5};
    vec_t vecs [15];

    logic [31:0] got_d [$];
    logic [4:0]  got_t [$];
    int          got_c [$];

    assign aux_valid = in_valid & aux_en;

    always #5 clk = ~clk;

    pipelined_shifter #(.WIDTH(W), .PIPE(2), .TAG_W(TW)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_tag(ot[0]));

    pipelined_shifter #(.WIDTH(W), .PIPE(1), .TAG_W(TW)) u_p1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(aux_valid), .in_ready(rdy1),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_tag(ot[1]));

    pipelined_shifter #(.WIDTH(W), .PIPE(5), .TAG_W(TW)) u_p5 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(aux_valid), .in_ready(rdy5),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_tag(ot[2]));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh,
                         input logic [4:0] tag);
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        in_tag   = tag;
        in_valid = 1'b1;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] d,
                          input logic [4:0] sh, input logic [4:0] tag, input logic [31:0] exp);
        logic [2:0] seen;
        int n;
        drive(op, d, sh, tag);
        #1;
        n = 0;
        while (!(in_ready && (!aux_en || (rdy1 && rdy5))) && n < 10) begin
            step();
            n++;
        end
        check({name, " accept"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        seen = '0;
        for (int c = 1; c <= 8; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (!seen[k] && ov[k] && (k == 0 || aux_en)) begin
                    seen[k] = 1'b1;
                    check($sformatf("%s p%0d data", name, pl[k]), od[k], exp);
                    check($sformatf("%s p%0d tag", name, pl[k]), ot[k], tag);
                    check($sformatf("%s p%0d latency", name, pl[k]), c, pl[k]);
                end
            end
            step();
        end
        check({name, " done p2"}, seen[0], 1);
        if (aux_en) begin
            check({name, " done p1"}, seen[1], 1);
            check({name, " done p5"}, seen[2], 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int base;

        vecs = '{
            '{3'b010, 32'h80000000, 5'd4,  32'hF8000000},
            '{3'b000, 32'h80000000, 5'd4,  32'h08000000},
            '{3'b001, 32'h0000000F, 5'd28, 32'hF0000000},
            '{3'b101, 32'h80000001, 5'd1,  32'h00000003},
            '{3'b100, 32'h00000001, 5'd4,  32'h10000000},
            '{3'b100, 32'h12345678, 5'd0,  32'h12345678},
            '{3'b111, 32'hDEADBEEF, 5'd5,  32'hDEADBEEF},
            '{3'b011, 32'hCAFEF00D, 5'd13, 32'hCAFEF00D},
            '{3'b101, 32'h12345678, 5'd8,  32'h34567812},
            '{3'b100, 32'h12345678, 5'd8,  32'h78123456},
            '{3'b010, 32'h7FFFFFF0, 5'd4,  32'h07FFFFFF},
            '{3'b010, 32'h80000000, 5'd31, 32'hFFFFFFFF},
            '{3'b001, 32'hFFFFFFFF, 5'd31, 32'h80000000},
            '{3'b101, 32'h80000000, 5'd31, 32'h40000000},
            '{3'b110, 32'h0BADF00D, 5'd7,  32'h0BADF00D}
        };

        // reset state
        step();
        check("rst out_valid", ov[0], 0);
        check("rst out_data", od[0], 0);
        check("rst out_tag", ot[0], 0);
        rst = 1'b0;
        #1;
        check("rst in_ready", in_ready, 1);

        // functional vectors on all three pipeline depths
        step();
        aux_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].d, vecs[i].sh, 5'(i + 1), vecs[i].e);
        end
        aux_en = 1'b0;

        // back-to-back stream
        out_ready = 1'b1;
        got_d.delete(); got_t.delete(); got_c.delete();
        for (int c = 0; c < 16; c++) begin
            if (c < 8) drive(3'b001, 32'h1, 5'(c), 5'(c));
            else in_valid = 1'b0;
            #1;
            if (c < 8) check($sformatf("stream in_ready %0d", c), in_ready, 1);
            if (ov[0]) begin
                got_d.push_back(od[0]); got_t.push_back(ot[0]); got_c.push_back(c);
            end
            step();
        end
        check("stream count", got_t.size(), 8);
        if (got_t.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                check($sformatf("stream tag %0d", k), got_t[k], k);
                check($sformatf("stream data %0d", k), got_d[k], 32'h1 << k);
                check($sformatf("stream cycle %0d", k), got_c[k] - got_c[0], k);
            end
        end

        // backpressure: two accepts, then stall with the output held
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            drive(3'b001, 32'h1, 5'(3 * idx), 5'(10 + idx));
            #1;
            check($sformatf("bp in_ready %0d", c), in_ready, (c < 2) ? 1 : 0);
            if (in_ready) idx++;
            if (c >= 2) begin
                check($sformatf("bp hold valid %0d", c), ov[0], 1);
                check($sformatf("bp hold data %0d", c), od[0], 32'h1);
                check($sformatf("bp hold tag %0d", c), ot[0], 10);
            end
            step();
        end
        check("bp accepted", idx, 2);
        out_ready = 1'b1;
        got_d.delete(); got_t.delete(); got_c.delete();
        for (int c = 0; c < 14; c++) begin
            if (idx < 4) drive(3'b001, 32'h1, 5'(3 * idx), 5'(10 + idx));
            else in_valid = 1'b0;
            #1;
            if (in_valid && in_ready) idx++;
            if (ov[0]) begin
                got_d.push_back(od[0]); got_t.push_back(ot[0]);
            end
            step();
        end
        check("bp drain count", got_t.size(), 4);
        if (got_t.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("bp drain tag %0d", k), got_t[k], 10 + k);
                check($sformatf("bp drain data %0d", k), got_d[k], 32'h1 << (3 * k));
            end
        end

        // flush with two ops in flight
        out_ready = 1'b0;
        drive(3'b011, 32'h11111111, 5'd0, 5'd20);
        step();
        drive(3'b011, 32'h22222222, 5'd0, 5'd21);
        step();
        flush = 1'b1;
        drive(3'b011, 32'h33333333, 5'd0, 5'd22);
        #1;
        check("flush in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush out_valid", ov[0], 0);
        out_ready = 1'b1;
        drive(3'b000, 32'h000000F0, 5'd4, 5'd23);
        #1;
        check("post flush accept", in_ready, 1);
        step();
        in_valid = 1'b0;
        got_d.delete(); got_t.delete();
        for (int c = 0; c < 8; c++) begin
            if (ov[0]) begin
                got_d.push_back(od[0]); got_t.push_back(ot[0]);
            end
            step();
        end
        check("post flush count", got_t.size(), 1);
        if (got_t.size() == 1) begin
            check("post flush tag", got_t[0], 23);
            check("post flush data", got_d[0], 32'h0000000F);
        end

        // asynchronous reset mid-stream
        drive(3'b011, 32'hA5A5A5A5, 5'd0, 5'd24);
        step();
        drive(3'b011, 32'h5A5A5A5A, 5'd0, 5'd25);
        step();
        check("pre rst out_valid", ov[0], 1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst out_valid", ov[0], 0);
        check("async rst out_data", od[0], 0);
        check("async rst out_tag", ot[0], 0);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post rst in_ready", in_ready, 1);
        step();
        check("post rst empty", ov[0], 0);
        base = n_fail;
        run_op("post rst op", 3'b100, 32'h000000FF, 5'd8, 5'd26, 32'hFF000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined barrel shifter for the execute path of the pipelined RISC-V core; replaces the single-cycle combinational shifter.
- Adds rotate modes, configurable data width and pipeline depth, a tag field, valid/ready handshaking with backpressure, and a flush.
- Sits between the issue stage and writeback arbitration.
- Throughput is one operation per cycle; latency is PIPE cycles.

Parameters:
- WIDTH, 32, data width. Power of two, 8..64.
- PIPE, 2, number of register stages, 1..SHW. The output register counts as one stage.
- TAG_W, 5, width of the tag carried alongside each operation (destination register id).
- SHW, derived as clog2(WIDTH), shift-amount width. Not user-overridable.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an operation this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHW  shift amount; naturally taken modulo WIDTH.
- in_op  in  3  operation code (see Behaviour).
- in_tag  in  TAG_W  tag, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Op encoding:
  - 000 SRL (logical right)
  - 001 SLL (logical left)
  - 010 SRA (arithmetic right, sign fill from bit WIDTH-1)
  - 011 PASS
  - 100 ROR
  - 101 ROL
  - 110, 111 PASS
  - Codes 000..011 are identical to the legacy 2-bit type encoding.
- Rotates are exact for all shamt values: ROL by 0 equals PASS.
- Shift network: SHW log levels, where level k shifts by 2^k when shamt[k]=1.
  - Levels are split across PIPE stages. Stage i holds levels floor(i*SHW/PIPE) .. floor((i+1)*SHW/PIPE)-1.
  - Each stage registers the partial result, the remaining shamt bits, the op, the tag and a valid bit.
- Latency: an operation accepted at edge N (in_valid & in_ready) presents out_valid=1 after edge N+PIPE-1, provided there is no backpressure.
- Handshake:
  - Stage i advances when its successor is empty or is itself advancing. The last stage advances on out_ready.
  - in_ready = ~flush & (stage0 empty | stage0 advancing).
  - Under continuous backpressure at most PIPE operations are held; none are lost, duplicated or reordered.
  - out_data and out_tag remain stable while out_valid=1 and out_ready=0.
- Flush: at the next edge, all valid bits clear. in_ready=0 during the flush cycle, so any input presented that cycle is not accepted. Data registers may retain stale values.
- Reset: asynchronous. Immediately clears all valid bits and all data, shamt, op and tag registers to 0. Therefore out_valid=0, out_data=0, out_tag=0, and in_ready=1 once rst deasserts. Reset mid-operation discards everything in flight.
- Simultaneous flush and out_ready: the result being output in that cycle counts as consumed; everything else is killed.
- Combinational paths: none from in_* to out_*. in_ready depends combinationally on out_ready through the advance chain; this is accepted.

Decomposition:
- Package shifter_pkg holds:
  - op encodings as localparams: OP_SRL, OP_SLL, OP_SRA, OP_PASS, OP_ROR, OP_ROL.
  - a helper function is_left(op).
- Sub-module shift_level: one combinational log level.
  - Parameters WIDTH and AMT (=2^k).
  - Inputs: data, enable, op.
  - Output: shifted data.
  - pipelined_shifter instantiates SHW of these and inserts the stage registers between groups of levels.

Test Plan:
- WIDTH=32, PIPE=2. SRA 0x80000000 by 4 → 0xF8000000. SRL same operand → 0x08000000. SLL 0x0000000F by 28 → 0xF0000000. out_valid appears 2 cycles after accept. Repeat with PIPE=1 and PIPE=5 and check latencies of 1 and 5.
- ROL 0x80000001 by 1 → 0x00000003. ROR 0x00000001 by 4 → 0x10000000. ROR 0x12345678 by 0 → 0x12345678. Op 111 → PASS.
- Back-to-back stream of 8 ops with tags 0..7 and out_ready=1 → 8 results on consecutive cycles, tags in order, in_ready constantly 1.
- Hold out_ready=0 for 4 cycles with in_valid=1 → in_ready drops after 2 accepts, output held stable. Release out_ready → remaining ops drain in order, with no loss and no duplicates.
- Assert flush with 2 ops in flight and in_valid=1 → out_valid=0 the following cycle, flushed-cycle input not accepted, next input completes normally.
- Assert rst asynchronously mid-stream, between clock edges → out_valid, out_data and out_tag go to 0 before the next edge. After release, in_ready=1 and a new op completes with the correct result.
